// File: rtl/sdram_test_pkg.sv
// sdram_test_pkg
//   Shared types and helpers for the SDRAM DMA write/read-back test.
//   - state_e  : read-checker FSM states
//   - exp_word : reference pattern {~k, k} for word index k, built at any even
//                data width up to MAX_DATA_W (caller takes the low DATA_W bits)
//   - DEF_*    : default bus widths
package sdram_test_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;
  localparam int MAX_DATA_W = 512;
  localparam int MAX_HALF_W = MAX_DATA_W / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Low half carries k, the half above it carries ~k. k is truncated to
  // half_w bits; everything above 2*half_w stays zero so a zero-extended
  // beat can be compared directly against the full return value.
  function automatic logic [MAX_DATA_W-1:0] exp_word(input logic [MAX_HALF_W-1:0] k,
                                                     input int half_w);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_HALF_W; i++) begin
      if (i < half_w) begin
        w[i]          = k[i];
        w[i + half_w] = ~k[i];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sdram_read_checker_if.sv
// sdram_read_checker_if
//   Avalon-MM read-master bundle (burst capable).
//   master: drives address/burstcount/read, receives waitrequest/readdata/readdatavalid
//   slave : the mirror image
interface sdram_read_checker_if
  import sdram_test_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = 8
) ();

  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               read;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output address, burstcount, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/sdram_burst_calc.sv
// sdram_burst_calc
//   Combinational burst sizing shared by burst readers/writers.
//   remaining_i  : words still to transfer
//   beat_idx_i   : beats already seen in the current burst
//   burst_len_i  : length of the current burst
//   burstcount_o : min(MAX_BURST, remaining_i)
//   last_beat_o  : beat_idx_i is the final beat of the current burst
module sdram_burst_calc #(
  parameter int CNT_W     = 32,
  parameter int BURST_W   = 8,
  parameter int MAX_BURST = 16
) (
  input  logic [CNT_W-1:0]   remaining_i,
  input  logic [BURST_W-1:0] beat_idx_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic [BURST_W-1:0] burstcount_o,
  output logic               last_beat_o
);

  // Below MAX_BURST the remainder fits in BURST_W bits since
  // MAX_BURST <= 2**(BURST_W-1).
  always_comb begin
    if (remaining_i >= CNT_W'(MAX_BURST)) burstcount_o = BURST_W'(MAX_BURST);
    else                                  burstcount_o = remaining_i[BURST_W-1:0];
  end

  assign last_beat_o = (beat_idx_i == burst_len_i - BURST_W'(1));

endmodule

// File: rtl/sdram_read_checker.sv
// sdram_read_checker
//   Reads back a buffer written by the DMA write test in Avalon bursts and
//   checks each beat against {~k, k}, k = word index from the buffer start.
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   start_stb_i           : one-cycle start; base_addr_i/size_i sampled with it
//   avm                   : Avalon-MM read master (one burst outstanding)
//   busy_o                : run in progress
//   done_stb_o            : one-cycle completion pulse (IRQ source)
//   err_cnt_o             : mismatching beats, saturating
//   first_err_valid_o/addr: first mismatching word address of this run
//   cycle_cnt_o           : cycles busy_o was high during the run
module sdram_read_checker
  import sdram_test_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_W   = 8,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_stb_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [CNT_W-1:0]     size_i,
  sdram_read_checker_if.master avm,
  output logic                 busy_o,
  output logic                 done_stb_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic                 first_err_valid_o,
  output logic [ADDR_W-1:0]    first_err_addr_o,
  output logic [CNT_W-1:0]     cycle_cnt_o
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [BURST_W-1:0] blen_q, blen_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               fev_q, fev_d;
  logic [ADDR_W-1:0]  faddr_q, faddr_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ADDR_W-1:0]     cur_addr;
  logic [BURST_W-1:0]    burst_len;
  logic                  last_beat;
  logic [MAX_DATA_W-1:0] exp_full;
  logic                  mismatch;
  logic                  avm_read;
  logic [ADDR_W-1:0]     avm_addr;
  logic [BURST_W-1:0]    avm_bc;

  // Address wraps modulo 2**ADDR_W by construction.
  assign cur_addr = base_q + ADDR_W'(k_q);

  sdram_burst_calc #(
    .CNT_W    (CNT_W),
    .BURST_W  (BURST_W),
    .MAX_BURST(MAX_BURST)
  ) u_burst_calc (
    .remaining_i (size_q - k_q),
    .beat_idx_i  (beat_q),
    .burst_len_i (blen_q),
    .burstcount_o(burst_len),
    .last_beat_o (last_beat)
  );

  assign exp_full = exp_word(MAX_HALF_W'(k_q), DATA_W / 2);
  assign mismatch = (MAX_DATA_W'(avm.readdata) != exp_full);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    size_d   = size_q;
    k_d      = k_q;
    beat_d   = beat_q;
    blen_d   = blen_q;
    err_d    = err_q;
    fev_d    = fev_q;
    faddr_d  = faddr_q;
    cyc_d    = cyc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    avm_read = 1'b0;
    avm_addr = '0;
    avm_bc   = '0;

    if (busy_q) cyc_d = cyc_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start_stb_i) begin
          base_d  = base_addr_i;
          size_d  = size_i;
          k_d     = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          faddr_d = '0;
          cyc_d   = '0;
          busy_d  = 1'b1;
          state_d = (size_i == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        // Request fields derive only from registered state, so they stay
        // put for as long as the slave stalls.
        avm_read = 1'b1;
        avm_addr = cur_addr;
        avm_bc   = burst_len;
        if (!avm.waitrequest) begin
          beat_d  = '0;
          blen_d  = burst_len;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (avm.readdatavalid) begin
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (!fev_q) begin
              fev_d   = 1'b1;
              faddr_d = cur_addr;
            end
          end
          k_d    = k_q + CNT_W'(1);
          beat_d = beat_q + BURST_W'(1);
          if (last_beat) state_d = (k_d == size_q) ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      size_q  <= '0;
      k_q     <= '0;
      beat_q  <= '0;
      blen_q  <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      faddr_q <= '0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      size_q  <= size_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      blen_q  <= blen_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      faddr_q <= faddr_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign avm.read          = avm_read;
  assign avm.address       = avm_addr;
  assign avm.burstcount    = avm_bc;
  assign busy_o            = busy_q;
  assign done_stb_o        = done_q;
  assign err_cnt_o         = err_q;
  assign first_err_valid_o = fev_q;
  assign first_err_addr_o  = faddr_q;
  assign cycle_cnt_o       = cyc_q;

endmodule

// File: doc/sdram_read_checker.md
Name: sdram_read_checker

Overview:
- Read-back stage for the FPGA-to-SDRAM DMA write test.
- After the write test fills a buffer, the CPU starts this block through control registers. It reads the same buffer over the 128-bit sdram0 Avalon-MM master port using bursts.
- Each beat is compared against the write pattern {~k[63:0], k[63:0]}, where k is the word index from the buffer start.
- Reports busy, an error count, the first failing address, cycle count and a done strobe for the IRQ.

Parameters:
- ADDR_W, 28, Avalon word-address width (one address = one 128-bit word).
- DATA_W, 128, Avalon data width; must be even, pattern half-width = DATA_W/2.
- BURST_W, 8, burstcount port width.
- MAX_BURST, 16, maximum beats per burst; 1..2**(BURST_W-1).
- CNT_W, 32, width of size, error and cycle counters.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous reset, active-low
- start_stb_i  in  1  one-cycle start strobe (edge-detected from CR bit)
- base_addr_i  in  ADDR_W  first word address; sampled on start
- size_i  in  CNT_W  number of words to check; sampled on start
- avm_address_o  out  ADDR_W  burst start address
- avm_burstcount_o  out  BURST_W  beats in current burst
- avm_read_o  out  1  read request
- avm_waitrequest_i  in  1  slave stall
- avm_readdata_i  in  DATA_W  read beat
- avm_readdatavalid_i  in  1  beat valid
- busy_o  out  1  check in progress
- done_stb_o  out  1  one-cycle pulse at completion (IRQ source)
- err_cnt_o  out  CNT_W  mismatching beats, saturating
- first_err_valid_o  out  1  at least one mismatch seen this run
- first_err_addr_o  out  ADDR_W  address of first mismatching word
- cycle_cnt_o  out  CNT_W  cycles from start to done

Behaviour:
- Reset (rst_n_i=0 at posedge):
  - state IDLE; all outputs 0; internal counters 0.
  - Reset mid-run aborts immediately, avm_read_o drops next cycle, no done_stb_o.
- FSM states: IDLE, REQ, DATA, DONE.
- IDLE:
  - On start_stb_i: latch base/size; clear err_cnt, first_err_*, cycle_cnt, word index k; busy_o=1.
  - size_i==0 -> DONE, else -> REQ.
  - start_stb_i while not IDLE is ignored.
- REQ:
  - avm_read_o=1; avm_address_o = base+k; avm_burstcount_o = min(MAX_BURST, size-k).
  - Address, burstcount and read are held stable while avm_waitrequest_i=1.
  - Accepted on the cycle read=1 and waitrequest=0 -> DATA.
- DATA:
  - avm_read_o=0; one burst outstanding at most.
  - Each avm_readdatavalid_i beat:
    - compare avm_readdata_i with {~k, k}, with k zero-extended/truncated to DATA_W/2;
    - on mismatch, increment err_cnt (saturate at all-ones); if first_err_valid_o=0, latch first_err_addr_o = base+k and set first_err_valid_o;
    - increment k.
  - After the last beat of the burst: if k==size -> DONE, else -> REQ on the next cycle.
- readdatavalid outside DATA is ignored (no compare, no count).
- DONE: done_stb_o=1 for exactly one cycle, busy_o=0 from the same edge, -> IDLE.
- cycle_cnt increments every cycle busy_o=1, so size 0 gives cycle_cnt=1.
- Results hold until the next start.
- Address arithmetic is modulo 2**ADDR_W; wrap past the top is legal and not flagged.

Decomposition:
- Package sdram_test_pkg:
  - state enum;
  - function exp_word(k) returning {~k, k} at DATA_W, shared with the write generator;
  - localparam defaults for DATA_W/ADDR_W.
- Sub-module sdram_burst_calc: combinational min(MAX_BURST, remaining) plus last-beat detect; reused by a future burst writer.

Test Plan:
- Pattern fill, size=40, MAX_BURST=16, slave no stall -> bursts of 16,16,8 at base, base+16, base+32. err_cnt=0, first_err_valid=0, exactly one done_stb.
- Same fill, corrupt word 21 and word 37 -> err_cnt=2, first_err_addr=base+21, first_err_valid=1.
- waitrequest held high 5 cycles on each request -> address/burstcount/read stable throughout. Results are identical to the no-stall run; cycle_cnt larger by 15.
- size=0 -> no avm_read_o, busy high one cycle, done_stb next, cycle_cnt=1.
- start_stb pulsed during DATA, plus stray readdatavalid in IDLE -> both ignored, counters unchanged.
- rst_n_i low for one cycle mid-burst (after 5 of 16 beats) -> all outputs 0, no done_stb. A new start with size=16 then completes with err_cnt=0.
